// File: rtl/gemm_tile_sequencer.sv
// M-tile x K-tile address/control sequencer for the weight-stationary systolic MAC array.
// Optional perf counters (stall/total cycles) are built when GEMM_SEQ_PERF_CNT_EN is defined.
module gemm_tile_sequencer #(
    parameter int MAC_ROW         = 16,
    parameter int PIPE_LAT        = 34,
    parameter int W_ADDR_BIT      = 11,
    parameter int INPUT_ADDR_BIT  = 12,
    parameter int OUTPUT_ADDR_BIT = 10,
    parameter int M_TILE_BIT      = 4,
    parameter int K_TILE_BIT      = 6,
    parameter int N_COL_BIT       = 9
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start_in,
    input  logic [M_TILE_BIT-1:0]      cfg_m_tiles_in,
    input  logic [K_TILE_BIT-1:0]      cfg_k_tiles_in,
    input  logic [N_COL_BIT-1:0]       cfg_n_cols_in,
    output logic                       w_prefetch_out,
    output logic [W_ADDR_BIT-1:0]      w_addr_out,
    output logic                       w_read_en_out,
    output logic                       input_start_out,
    output logic [INPUT_ADDR_BIT-1:0]  input_addr_out,
    output logic                       input_read_en_out,
    output logic [OUTPUT_ADDR_BIT-1:0] output_addr_out,
    output logic                       output_write_en_out,
    output logic                       output_accum_out,
    input  logic                       output_ready_in,
    output logic                       busy_out,
    output logic                       done_out,
    output logic                       cfg_err_out
`ifdef GEMM_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]                perf_stall_out,
    output logic [31:0]                perf_total_out
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_WLOAD, S_STREAM, S_FLUSH, S_DRAIN, S_DONE} state_t;

    state_t                    state, state_nxt;
    logic [31:0]               cnt, cnt_nxt;
    logic [M_TILE_BIT-1:0]     mt, mt_nxt, m_cfg, m_cfg_nxt;
    logic [K_TILE_BIT-1:0]     kt, kt_nxt, k_cfg, k_cfg_nxt;
    logic [N_COL_BIT-1:0]      n_cfg, n_cfg_nxt;
    logic                      cfg_zero, start_ok, last_col;

    logic                       w_prefetch_nxt, w_read_en_nxt, input_start_nxt, input_read_en_nxt;
    logic                       output_write_en_nxt, output_accum_nxt, busy_nxt, done_nxt, cfg_err_nxt;
    logic [W_ADDR_BIT-1:0]      w_addr_nxt;
    logic [INPUT_ADDR_BIT-1:0]  input_addr_nxt;
    logic [OUTPUT_ADDR_BIT-1:0] output_addr_nxt;

    assign cfg_zero = (cfg_m_tiles_in == '0) || (cfg_k_tiles_in == '0) || (cfg_n_cols_in == '0);
    assign start_ok = start_in && (state == S_IDLE) && !cfg_zero;
    assign last_col = (cnt == 32'(n_cfg) - 32'd1);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        mt_nxt      = mt;
        kt_nxt      = kt;
        m_cfg_nxt   = m_cfg;
        k_cfg_nxt   = k_cfg;
        n_cfg_nxt   = n_cfg;
        cfg_err_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                if (start_in) begin
                    if (cfg_zero) begin
                        cfg_err_nxt = 1'b1;
                    end else begin
                        m_cfg_nxt = cfg_m_tiles_in;
                        k_cfg_nxt = cfg_k_tiles_in;
                        n_cfg_nxt = cfg_n_cols_in;
                        mt_nxt    = '0;
                        kt_nxt    = '0;
                        cnt_nxt   = '0;
                        state_nxt = S_WLOAD;
                    end
                end
            end
            S_WLOAD: begin
                if (cnt == 32'(MAC_ROW - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = S_STREAM;
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end
            S_STREAM: begin
                if (last_col) begin
                    cnt_nxt   = '0;
                    state_nxt = S_FLUSH;
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end
            S_FLUSH: begin
                if (cnt == 32'(PIPE_LAT - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = S_DRAIN;
                end else begin
                    cnt_nxt = cnt + 32'd1;
                end
            end
            S_DRAIN: begin
                // Column index only moves on an accepted write; a stall holds the address.
                if (output_write_en_out && output_ready_in) begin
                    if (last_col) begin
                        cnt_nxt   = '0;
                        state_nxt = S_WLOAD;
                        if (kt == k_cfg - K_TILE_BIT'(1)) begin
                            kt_nxt = '0;
                            if (mt == m_cfg - M_TILE_BIT'(1)) state_nxt = S_DONE;
                            else                               mt_nxt    = mt + M_TILE_BIT'(1);
                        end else begin
                            kt_nxt = kt + K_TILE_BIT'(1);
                        end
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        w_prefetch_nxt      = 1'b0;
        w_read_en_nxt       = 1'b0;
        w_addr_nxt          = '0;
        input_start_nxt     = 1'b0;
        input_read_en_nxt   = 1'b0;
        input_addr_nxt      = '0;
        output_write_en_nxt = 1'b0;
        output_accum_nxt    = 1'b0;
        output_addr_nxt     = '0;
        done_nxt            = 1'b0;
        busy_nxt            = 1'b0;

        case (state_nxt)
            S_WLOAD: begin
                busy_nxt       = 1'b1;
                w_read_en_nxt  = 1'b1;
                w_prefetch_nxt = (cnt_nxt == '0);
                w_addr_nxt     = W_ADDR_BIT'((32'(mt_nxt) * 32'(k_cfg_nxt) + 32'(kt_nxt))
                                             * 32'(MAC_ROW) + cnt_nxt);
            end
            S_STREAM: begin
                busy_nxt          = 1'b1;
                input_read_en_nxt = 1'b1;
                input_start_nxt   = (cnt_nxt == '0);
                input_addr_nxt    = INPUT_ADDR_BIT'(32'(kt_nxt) * 32'(n_cfg_nxt) + cnt_nxt);
            end
            S_FLUSH: busy_nxt = 1'b1;
            S_DRAIN: begin
                busy_nxt            = 1'b1;
                output_write_en_nxt = 1'b1;
                output_accum_nxt    = (kt_nxt != '0);
                output_addr_nxt     = OUTPUT_ADDR_BIT'(32'(mt_nxt) * 32'(n_cfg_nxt) + cnt_nxt);
            end
            S_DONE:  done_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state               <= S_IDLE;
            cnt                 <= '0;
            mt                  <= '0;
            kt                  <= '0;
            w_prefetch_out      <= 1'b0;
            w_read_en_out       <= 1'b0;
            w_addr_out          <= '0;
            input_start_out     <= 1'b0;
            input_read_en_out   <= 1'b0;
            input_addr_out      <= '0;
            output_write_en_out <= 1'b0;
            output_accum_out    <= 1'b0;
            output_addr_out     <= '0;
            busy_out            <= 1'b0;
            done_out            <= 1'b0;
            cfg_err_out         <= 1'b0;
        end else begin
            state               <= state_nxt;
            cnt                 <= cnt_nxt;
            mt                  <= mt_nxt;
            kt                  <= kt_nxt;
            w_prefetch_out      <= w_prefetch_nxt;
            w_read_en_out       <= w_read_en_nxt;
            w_addr_out          <= w_addr_nxt;
            input_start_out     <= input_start_nxt;
            input_read_en_out   <= input_read_en_nxt;
            input_addr_out      <= input_addr_nxt;
            output_write_en_out <= output_write_en_nxt;
            output_accum_out    <= output_accum_nxt;
            output_addr_out     <= output_addr_nxt;
            busy_out            <= busy_nxt;
            done_out            <= done_nxt;
            cfg_err_out         <= cfg_err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        m_cfg <= m_cfg_nxt;
        k_cfg <= k_cfg_nxt;
        n_cfg <= n_cfg_nxt;
    end

`ifdef GEMM_SEQ_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_stall_out <= '0;
            perf_total_out <= '0;
        end else if (start_ok) begin
            perf_stall_out <= '0;
            perf_total_out <= '0;
        end else begin
            if (busy_out)                                  perf_total_out <= sat_inc(perf_total_out);
            if (output_write_en_out && !output_ready_in)   perf_stall_out <= sat_inc(perf_stall_out);
        end
    end
`endif

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Scoreboard bench for gemm_tile_sequencer: a loop-nest model fills expected read/write queues,
// a negedge monitor pops and compares whatever the sequencer issues.
module tb_gemm_tile_sequencer;

    localparam int MAC_ROW  = 16;
    localparam int PIPE_LAT = 34;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start_in;
    logic [3:0]  cfg_m_tiles_in;
    logic [5:0]  cfg_k_tiles_in;
    logic [8:0]  cfg_n_cols_in;
    logic        w_prefetch_out;
    logic [10:0] w_addr_out;
    logic        w_read_en_out;
    logic        input_start_out;
    logic [11:0] input_addr_out;
    logic        input_read_en_out;
    logic [9:0]  output_addr_out;
    logic        output_write_en_out;
    logic        output_accum_out;
    logic        output_ready_in;
    logic        busy_out;
    logic        done_out;
    logic        cfg_err_out;
`ifdef GEMM_SEQ_PERF_CNT_EN
    logic [31:0] perf_stall_out;
    logic [31:0] perf_total_out;
`endif

    gemm_tile_sequencer #(
        .MAC_ROW(MAC_ROW), .PIPE_LAT(PIPE_LAT), .W_ADDR_BIT(11), .INPUT_ADDR_BIT(12),
        .OUTPUT_ADDR_BIT(10), .M_TILE_BIT(4), .K_TILE_BIT(6), .N_COL_BIT(9)
    ) dut (
        .clk(clk), .rstn(rstn), .start_in(start_in),
        .cfg_m_tiles_in(cfg_m_tiles_in), .cfg_k_tiles_in(cfg_k_tiles_in), .cfg_n_cols_in(cfg_n_cols_in),
        .w_prefetch_out(w_prefetch_out), .w_addr_out(w_addr_out), .w_read_en_out(w_read_en_out),
        .input_start_out(input_start_out), .input_addr_out(input_addr_out),
        .input_read_en_out(input_read_en_out), .output_addr_out(output_addr_out),
        .output_write_en_out(output_write_en_out), .output_accum_out(output_accum_out),
        .output_ready_in(output_ready_in), .busy_out(busy_out), .done_out(done_out),
        .cfg_err_out(cfg_err_out)
`ifdef GEMM_SEQ_PERF_CNT_EN
        , .perf_stall_out(perf_stall_out), .perf_total_out(perf_total_out)
`endif
    );

    typedef struct packed {
        logic        flag;
        logic [15:0] addr;
    } ev_t;

    ev_t w_q[$];
    ev_t i_q[$];
    ev_t o_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int t0 = 0;
    int done_cyc = 0;
    int last_acc = 0;
    int rdy_mode = 0;
    bit done_seen = 1'b0;
    bit err_ok = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected traffic straight from the loop nest: mt outer, kt inner.
    task automatic push_model(input int m, input int k, input int n);
        for (int mt = 0; mt < m; mt++)
            for (int kt = 0; kt < k; kt++) begin
                for (int r = 0; r < MAC_ROW; r++)
                    w_q.push_back('{flag: (r == 0), addr: 16'(((mt * k + kt) * MAC_ROW + r) % 2048)});
                for (int c = 0; c < n; c++)
                    i_q.push_back('{flag: (c == 0), addr: 16'((kt * n + c) % 4096)});
                for (int c = 0; c < n; c++)
                    o_q.push_back('{flag: (kt != 0), addr: 16'((mt * n + c) % 1024)});
            end
    endtask

    // Ready driver: 0 = always ready, 1 = random, 2 = five stall cycles at drain column 1.
    initial begin
        output_ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       output_ready_in = 1'b1;
                1:       output_ready_in = ($urandom_range(0, 2) != 0);
                default: output_ready_in = !((cyc - t0) >= 55 && (cyc - t0) <= 59);
            endcase
        end
    end

    always @(negedge clk) begin : monitor
        ev_t e;
        if (rstn) begin
            if (w_read_en_out) begin
                if (w_q.size() == 0) chk("w_extra", 32'(w_read_en_out), 32'd0);
                else begin
                    e = w_q.pop_front();
                    chk("w_addr", 32'(w_addr_out), 32'(e.addr));
                    chk("w_prefetch", 32'(w_prefetch_out), 32'(e.flag));
                end
            end else if (w_prefetch_out) chk("w_prefetch_noen", 32'(w_prefetch_out), 32'd0);

            if (input_read_en_out) begin
                if (i_q.size() == 0) chk("in_extra", 32'(input_read_en_out), 32'd0);
                else begin
                    e = i_q.pop_front();
                    chk("in_addr", 32'(input_addr_out), 32'(e.addr));
                    chk("in_start", 32'(input_start_out), 32'(e.flag));
                end
            end else if (input_start_out) chk("in_start_noen", 32'(input_start_out), 32'd0);

            if (output_write_en_out) begin
                if (o_q.size() == 0) chk("out_extra", 32'(output_write_en_out), 32'd0);
                else begin
                    chk("out_addr", 32'(output_addr_out), 32'(o_q[0].addr));
                    chk("out_accum", 32'(output_accum_out), 32'(o_q[0].flag));
                    if (output_ready_in) begin
                        void'(o_q.pop_front());
                        last_acc = cyc;
                    end
                end
            end

            if (done_out) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                chk("done_busy", 32'(busy_out), 32'd0);
            end
            if (cfg_err_out) chk("cfg_err_spurious", 32'(cfg_err_out), 32'(err_ok));
        end
    end

    task automatic run_job(input int m, input int k, input int n, input int mode,
                           input bit timed, input int exp_stall, input bit poke);
        int lat;
        lat = 1 + m * k * (MAC_ROW + 2 * n + PIPE_LAT) + exp_stall;
        push_model(m, k, n);
        rdy_mode  = mode;
        done_seen = 1'b0;
        @(posedge clk); #1;
        start_in = 1'b1;
        cfg_m_tiles_in = 4'(m);
        cfg_k_tiles_in = 6'(k);
        cfg_n_cols_in  = 9'(n);
        t0 = cyc;
        @(negedge clk);
        chk("busy_before_start", 32'(busy_out), 32'd0);
        @(posedge clk); #1;
        start_in = 1'b0;
        cfg_m_tiles_in = 4'($urandom);
        cfg_k_tiles_in = 6'($urandom);
        cfg_n_cols_in  = 9'($urandom);
        @(negedge clk);
        chk("busy_after_start", 32'(busy_out), 32'd1);
        for (int i = 0; i < 20000 && !done_seen; i++) begin
            @(posedge clk); #1;
            if (poke) begin
                start_in = ($urandom_range(0, 7) == 0);
                cfg_m_tiles_in = 4'($urandom);
                cfg_k_tiles_in = 6'($urandom);
                cfg_n_cols_in  = 9'($urandom);
            end
        end
        start_in = 1'b0;
        chk("done_timeout", 32'(done_seen), 32'd1);
        if (done_seen) begin
            if (timed) chk("done_latency", 32'(done_cyc - t0), 32'(lat));
            chk("done_after_last_write", 32'(done_cyc - last_acc), 32'd1);
            chk("w_left", 32'(w_q.size()), 32'd0);
            chk("in_left", 32'(i_q.size()), 32'd0);
            chk("out_left", 32'(o_q.size()), 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        chk("done_one_cycle", 32'(done_out), 32'd0);
        chk("busy_idle", 32'(busy_out), 32'd0);
`ifdef GEMM_SEQ_PERF_CNT_EN
        if (timed) begin
            chk("perf_stall", perf_stall_out, 32'(exp_stall));
            chk("perf_total", perf_total_out, 32'(lat - 1));
        end
`endif
        w_q.delete(); i_q.delete(); o_q.delete();
        rdy_mode = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_w_en"},  32'(w_read_en_out), 32'd0);
        chk({tag, "_w_pf"},  32'(w_prefetch_out), 32'd0);
        chk({tag, "_w_addr"}, 32'(w_addr_out), 32'd0);
        chk({tag, "_in_en"}, 32'(input_read_en_out), 32'd0);
        chk({tag, "_in_st"}, 32'(input_start_out), 32'd0);
        chk({tag, "_in_addr"}, 32'(input_addr_out), 32'd0);
        chk({tag, "_out_en"}, 32'(output_write_en_out), 32'd0);
        chk({tag, "_out_acc"}, 32'(output_accum_out), 32'd0);
        chk({tag, "_out_addr"}, 32'(output_addr_out), 32'd0);
        chk({tag, "_busy"}, 32'(busy_out), 32'd0);
        chk({tag, "_done"}, 32'(done_out), 32'd0);
        chk({tag, "_err"},  32'(cfg_err_out), 32'd0);
    endtask

    initial begin
        rstn = 1'b0;
        start_in = 1'b0;
        cfg_m_tiles_in = '0;
        cfg_k_tiles_in = '0;
        cfg_n_cols_in  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
`ifdef GEMM_SEQ_PERF_CNT_EN
        chk("reset_perf_stall", perf_stall_out, 32'd0);
        chk("reset_perf_total", perf_total_out, 32'd0);
`endif
        @(posedge clk); #1;
        rstn = 1'b1;

        run_job(1, 1, 4, 0, 1'b1, 0, 1'b0);
        run_job(2, 3, 2, 0, 1'b1, 0, 1'b0);
        run_job(1, 1, 3, 2, 1'b1, 5, 1'b0);

        // Zero in any config field: error pulse only, nothing starts.
        for (int f = 0; f < 3; f++) begin
            @(posedge clk); #1;
            err_ok = 1'b1;
            start_in = 1'b1;
            cfg_m_tiles_in = (f == 0) ? 4'd0 : 4'd2;
            cfg_k_tiles_in = (f == 1) ? 6'd0 : 6'd3;
            cfg_n_cols_in  = (f == 2) ? 9'd0 : 9'd3;
            @(posedge clk); #1;
            start_in = 1'b0;
            @(negedge clk);
            chk("cfg_err_pulse", 32'(cfg_err_out), 32'd1);
            chk("cfg_err_busy", 32'(busy_out), 32'd0);
            @(posedge clk); #1;
            err_ok = 1'b0;
            @(negedge clk);
            chk("cfg_err_end", 32'(cfg_err_out), 32'd0);
            chk("cfg_err_busy_after", 32'(busy_out), 32'd0);
        end

        // Reset during STREAM of the second pass (interval t0+75..t0+78).
        push_model(1, 2, 4);
        done_seen = 1'b0;
        @(posedge clk); #1;
        start_in = 1'b1;
        cfg_m_tiles_in = 4'd1;
        cfg_k_tiles_in = 6'd2;
        cfg_n_cols_in  = 9'd4;
        t0 = cyc;
        @(posedge clk); #1;
        start_in = 1'b0;
        for (int i = 0; i < 200 && (cyc - t0) < 76; i++) begin
            @(posedge clk); #1;
        end
        chk("rst_point_reached", 32'(cyc - t0), 32'd76);
        chk("rst_in_stream", 32'(input_read_en_out), 32'd1);
        rstn = 1'b0;
        @(posedge clk); #1;
        w_q.delete(); i_q.delete(); o_q.delete();
        rstn = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        repeat (80) @(posedge clk);
        chk("midrst_no_done", 32'(done_seen), 32'd0);
        run_job(1, 1, 2, 0, 1'b1, 0, 1'b0);

        // Start pulses and config churn while busy must be ignored.
        run_job(2, 3, 2, 0, 1'b1, 0, 1'b1);

        for (int r = 0; r < 6; r++)
            run_job($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 6), 1, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
